// File: rtl/tiny_fir_mc.sv
// tiny_fir_mc -- time-shared multi-channel serial FIR filter.
//
// One multiply-accumulate unit serves G_NUM_CHANNELS independent channels
// that share a single set of G_NUM_TAPS coefficients. Coefficients and the
// per-channel sample history are held in inferred RAMs with a registered
// read port. Every channel keeps its own circular-buffer head pointer.
//
// Optional feature: define TINY_FIR_MC_SATURATE_EN to clamp the shifted
// accumulator to the signed G_DATA_WIDTH range. Without it the low
// G_DATA_WIDTH bits are taken (two's-complement wrap) and no clamp logic
// is built.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_enable              0 = synchronous soft stop (drops any in-flight output)
//   i_tap_din/_valid      coefficient stream, tap 0 first
//   o_tap_din_ready       coefficient accepted on valid & ready
//   o_tap_din_done        all taps loaded
//   i_tap_reload          pulse: restart coefficient loading
//   i_din/_channel/_valid, o_din_ready     sample input stream
//   o_dout/_channel/_valid, i_dout_ready   filtered output stream
module tiny_fir_mc #(
  parameter int G_NUM_TAPS     = 16,
  parameter int G_NUM_CHANNELS = 4,
  parameter int G_DATA_WIDTH   = 16,
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_OUT_SHIFT    = 15,
  localparam int LP_CH_W = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [G_TAP_WIDTH-1:0]  i_tap_din,
  input  logic                    i_tap_din_valid,
  output logic                    o_tap_din_ready,
  output logic                    o_tap_din_done,
  input  logic                    i_tap_reload,
  input  logic [G_DATA_WIDTH-1:0] i_din,
  input  logic [LP_CH_W-1:0]      i_din_channel,
  input  logic                    i_din_valid,
  output logic                    o_din_ready,
  output logic [G_DATA_WIDTH-1:0] o_dout,
  output logic [LP_CH_W-1:0]      o_dout_channel,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready
);

  localparam int LP_IDX_W  = $clog2(G_NUM_TAPS);
  localparam int LP_HA     = G_NUM_CHANNELS * G_NUM_TAPS;
  localparam int LP_HA_W   = $clog2(LP_HA);
  localparam int LP_PROD_W = G_DATA_WIDTH + G_TAP_WIDTH;
  localparam int LP_ACC_W  = LP_PROD_W + LP_IDX_W;

  typedef enum logic [2:0] {
    SM_CLEAR, SM_LOAD_TAPS, SM_GET_INPUT, SM_CALC_MULT, SM_ACCUMULATE, SM_SEND_OUTPUT
  } t_state;

  t_state r_state, w_state_nxt;

  logic [LP_HA_W-1:0]             r_clr_cnt;
  logic [LP_IDX_W-1:0]            r_tap_idx;
  logic                           r_tap_done;
  logic [LP_IDX_W-1:0]            r_k;
  logic [LP_CH_W-1:0]             r_ch;
  logic [LP_IDX_W-1:0]            r_head [G_NUM_CHANNELS];
  logic                           r_rd_vld;
  logic signed [LP_ACC_W-1:0]     r_acc;
  logic [G_DATA_WIDTH-1:0]        r_dout;
  logic [LP_CH_W-1:0]             r_dout_ch;
  logic                           r_dout_valid;

  logic [G_TAP_WIDTH-1:0]         r_tap_mem  [G_NUM_TAPS];
  logic [G_DATA_WIDTH-1:0]        r_hist_mem [LP_HA];
  logic signed [G_TAP_WIDTH-1:0]  r_tap_q;
  logic signed [G_DATA_WIDTH-1:0] r_hist_q;

  logic                           w_tap_acc, w_din_acc, w_out_hs, w_hist_we;
  logic [LP_IDX_W-1:0]            w_rd_idx;
  logic [LP_HA_W-1:0]             w_rd_addr, w_wr_addr;
  logic [G_DATA_WIDTH-1:0]        w_hist_wd;
  logic signed [LP_PROD_W-1:0]    w_prod;
  logic signed [LP_ACC_W-1:0]     w_prod_ext;
  logic [G_DATA_WIDTH-1:0]        w_narrow;

  // Handshake qualifiers. tap_reload wins over a pending sample, so din_ready
  // is withheld in that cycle rather than letting a transfer be silently lost.
  assign w_tap_acc = (r_state == SM_LOAD_TAPS) && i_enable && i_tap_din_valid && !i_tap_reload;
  assign w_din_acc = (r_state == SM_GET_INPUT) && i_enable && i_din_valid && !i_tap_reload;
  assign w_out_hs  = r_dout_valid && i_dout_ready;

  // History word for tap k is (head - k) mod N; the index width gives the wrap.
  // Address is {channel, index}; the cast drops the unused channel bit when C=1.
  assign w_rd_idx  = r_head[r_ch] - r_k;
  assign w_rd_addr = LP_HA_W'({r_ch, w_rd_idx});
  assign w_wr_addr = (r_state == SM_CLEAR) ? r_clr_cnt
                                           : LP_HA_W'({i_din_channel, r_head[i_din_channel]});
  assign w_hist_we = ((r_state == SM_CLEAR) && i_enable) || w_din_acc;
  assign w_hist_wd = (r_state == SM_CLEAR) ? '0 : i_din;

  // RAMs: one write port, registered read. No reset, so history is zeroed by SM_CLEAR.
  always_ff @(posedge i_clk) begin
    if (w_tap_acc) r_tap_mem[r_tap_idx] <= i_tap_din;
    if (w_hist_we) r_hist_mem[w_wr_addr] <= w_hist_wd;
    r_tap_q  <= r_tap_mem[r_k];
    r_hist_q <= r_hist_mem[w_rd_addr];
  end

  assign w_prod     = LP_PROD_W'(r_tap_q) * LP_PROD_W'(r_hist_q);
  assign w_prod_ext = {{LP_IDX_W{w_prod[LP_PROD_W-1]}}, w_prod};

`ifdef TINY_FIR_MC_SATURATE_EN
  logic signed [LP_ACC_W-1:0] w_shifted;
  logic                       w_fits;
  assign w_shifted = r_acc >>> G_OUT_SHIFT;
  // Fits when every bit above the output sign bit matches it.
  assign w_fits    = (&w_shifted[LP_ACC_W-1:G_DATA_WIDTH-1]) | ~(|w_shifted[LP_ACC_W-1:G_DATA_WIDTH-1]);
  assign w_narrow  = w_fits ? w_shifted[G_DATA_WIDTH-1:0]
                   : (w_shifted[LP_ACC_W-1] ? {1'b1, {(G_DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(G_DATA_WIDTH-1){1'b1}}});
`else
  assign w_narrow  = G_DATA_WIDTH'(r_acc >>> G_OUT_SHIFT);
`endif

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= SM_CLEAR;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      // Soft stop: clearing just pauses, everything else falls back to idle.
      if (r_state != SM_CLEAR) w_state_nxt = r_tap_done ? SM_GET_INPUT : SM_LOAD_TAPS;
    end else begin
      case (r_state)
        SM_CLEAR:       if (r_clr_cnt == LP_HA_W'(LP_HA - 1))
                          w_state_nxt = r_tap_done ? SM_GET_INPUT : SM_LOAD_TAPS;
        SM_LOAD_TAPS:   if (w_tap_acc && (r_tap_idx == LP_IDX_W'(G_NUM_TAPS - 1)))
                          w_state_nxt = SM_GET_INPUT;
        SM_GET_INPUT:   if (i_tap_reload)   w_state_nxt = SM_LOAD_TAPS;
                        else if (w_din_acc) w_state_nxt = SM_CALC_MULT;
        SM_CALC_MULT:   if (r_k == LP_IDX_W'(G_NUM_TAPS - 1)) w_state_nxt = SM_ACCUMULATE;
        SM_ACCUMULATE:  w_state_nxt = SM_SEND_OUTPUT;
        SM_SEND_OUTPUT: if (w_out_hs) w_state_nxt = SM_GET_INPUT;
        default:        w_state_nxt = SM_CLEAR;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_tap_din_ready = 1'b0;
    o_din_ready     = 1'b0;
    if (i_enable) begin
      o_tap_din_ready = (r_state == SM_LOAD_TAPS);
      o_din_ready     = (r_state == SM_GET_INPUT) && !i_tap_reload;
    end
  end

  // Datapath and bookkeeping
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_clr_cnt    <= '0;
      r_tap_idx    <= '0;
      r_tap_done   <= 1'b0;
      r_k          <= '0;
      r_ch         <= '0;
      r_rd_vld     <= 1'b0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < G_NUM_CHANNELS; i++) r_head[i] <= '0;
    end else begin
      if ((r_state == SM_CLEAR) && i_enable) r_clr_cnt <= r_clr_cnt + LP_HA_W'(1);

      if ((r_state == SM_LOAD_TAPS) && i_enable && i_tap_reload) begin
        r_tap_idx <= '0;
      end else if (w_tap_acc) begin
        r_tap_idx <= r_tap_idx + LP_IDX_W'(1);
        if (r_tap_idx == LP_IDX_W'(G_NUM_TAPS - 1)) r_tap_done <= 1'b1;
      end

      if ((r_state == SM_GET_INPUT) && i_enable && i_tap_reload) begin
        r_tap_done <= 1'b0;
        r_tap_idx  <= '0;
      end

      if (w_din_acc) begin
        r_ch  <= i_din_channel;
        r_k   <= '0;
        r_acc <= '0;
      end

      if ((r_state == SM_CALC_MULT) && i_enable) r_k <= r_k + LP_IDX_W'(1);

      // Read data trails the address by one cycle; accumulate behind it.
      r_rd_vld <= (r_state == SM_CALC_MULT) && i_enable;
      if (r_rd_vld && i_enable) r_acc <= r_acc + w_prod_ext;

      // A completed handshake always counts, even in a stop cycle, so the
      // head stays in step with what the sink actually received.
      if (w_out_hs) begin
        r_dout_valid <= 1'b0;
        r_head[r_ch] <= r_head[r_ch] + LP_IDX_W'(1);
      end else if (!i_enable) begin
        r_dout_valid <= 1'b0;
      end else if ((r_state == SM_SEND_OUTPUT) && !r_dout_valid) begin
        r_dout       <= w_narrow;
        r_dout_ch    <= r_ch;
        r_dout_valid <= 1'b1;
      end
    end
  end

  assign o_tap_din_done = r_tap_done;
  assign o_dout         = r_dout;
  assign o_dout_channel = r_dout_ch;
  assign o_dout_valid   = r_dout_valid;

endmodule

// File: tb/tb_tiny_fir_mc.sv
// Directed bench for tiny_fir_mc with N=4 taps, C=2 channels, shift 0.
module tb_tiny_fir_mc;
  localparam int N = 4;
  localparam int C = 2;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [15:0] tap_din;
  logic        tap_valid, tap_ready, tap_done, tap_reload;
  logic [15:0] din;
  logic        din_ch, din_valid, din_ready;
  logic [15:0] dout;
  logic        dout_ch, dout_valid, dout_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tiny_fir_mc #(
    .G_NUM_TAPS(N), .G_NUM_CHANNELS(C), .G_DATA_WIDTH(16), .G_TAP_WIDTH(16), .G_OUT_SHIFT(0)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(enable),
    .i_tap_din(tap_din), .i_tap_din_valid(tap_valid), .o_tap_din_ready(tap_ready),
    .o_tap_din_done(tap_done), .i_tap_reload(tap_reload),
    .i_din(din), .i_din_channel(din_ch), .i_din_valid(din_valid), .o_din_ready(din_ready),
    .o_dout(dout), .o_dout_channel(dout_ch), .o_dout_valid(dout_valid), .i_dout_ready(dout_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Release reset and count cycles until coefficient loading opens.
  task automatic release_and_count(input string tag);
    int cyc = 0;
    bit din_seen = 1'b0;
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (din_ready) din_seen = 1'b1;
    end while (!tap_ready && cyc < 100);
    chk({tag, "_clr_cycles"}, cyc, C * N);
    chk({tag, "_clr_din_rdy"}, din_seen, 0);
  endtask

  task automatic load_taps(input logic [15:0] t0, t1, t2, t3);
    logic [15:0] t [4];
    int g;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    for (int i = 0; i < 4; i++) begin
      tap_din = t[i];
      tap_valid = 1'b1;
      g = 0;
      while (!tap_ready && g < 100) begin @(negedge clk); g++; end
      @(negedge clk);
    end
    tap_valid = 1'b0;
    chk("taps_done", tap_done, 1);
    chk("taps_rdy_drop", tap_ready, 0);
  endtask

  task automatic pulse_reload();
    tap_reload = 1'b1;
    @(negedge clk);
    tap_reload = 1'b0;
    chk("reload_done_clr", tap_done, 0);
    chk("reload_tap_rdy", tap_ready, 1);
  endtask

  task automatic send(input logic ch, input logic [15:0] v);
    int g = 0;
    din = v; din_ch = ch; din_valid = 1'b1;
    while (!din_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("din_ready_timeout", 0, 1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Called half a cycle after the accept edge; returns edges until dout_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!dout_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic run(input string tag, input logic ch, input logic [15:0] v, input logic [15:0] exp);
    int lat;
    send(ch, v);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, N + 2);
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_ch"}, dout_ch, ch);
    @(negedge clk);
    chk({tag, "_din_rdy"}, din_ready, 1);
  endtask

  task automatic drain(input logic ch, input logic [15:0] v);
    int lat;
    send(ch, v);
    wait_valid(lat);
    if (lat >= 50) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [15:0] imp_exp [5];
    logic [15:0] sat_exp;
    rst_n = 1'b0; enable = 1'b1; tap_din = '0; tap_valid = 1'b0; tap_reload = 1'b0;
    din = '0; din_ch = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_tap_rdy", tap_ready, 0);
    chk("rst_tap_done", tap_done, 0);
    chk("rst_din_rdy", din_ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_dout_vld", dout_valid, 0);

    release_and_count("init");
    load_taps(16'd1, 16'd2, 16'd3, 16'd4);

    // Impulse on ch0
    imp_exp[0] = 16'd1; imp_exp[1] = 16'd2; imp_exp[2] = 16'd3; imp_exp[3] = 16'd4; imp_exp[4] = 16'd0;
    for (int i = 0; i < 5; i++)
      run($sformatf("imp%0d", i), 1'b0, (i == 0) ? 16'd1 : 16'd0, imp_exp[i]);

    // Channel isolation: ch0 impulse interleaved with ch1 zeros
    for (int i = 0; i < 4; i++) begin
      run($sformatf("iso_c0_%0d", i), 1'b0, (i == 0) ? 16'd1 : 16'd0, imp_exp[i]);
      run($sformatf("iso_c1_%0d", i), 1'b1, 16'd0, 16'd0);
    end

    // Backpressure on ch1: 5 * tap0 = 5
    dout_ready = 1'b0;
    send(1'b1, 16'd5);
    wait_valid(lat);
    chk("bp_lat", lat, N + 2);
    chk("bp_ch", dout_ch, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_dout_hold", dout, 16'd5);
      chk("bp_vld_hold", dout_valid, 1);
      chk("bp_din_rdy_low", din_ready, 0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_vld_after_hs", dout_valid, 0);
    chk("bp_din_rdy_after_hs", din_ready, 1);

    // Saturation / wrap: all taps and samples 0x7FFF, sum 0xFFFC0004
    pulse_reload();
    load_taps(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) drain(1'b0, 16'h7FFF);
`ifdef TINY_FIR_MC_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h0004;
`endif
    run("sat", 1'b0, 16'h7FFF, sat_exp);

    // Reset during SM_ACCUMULATE (N edges after the accept edge)
    send(1'b0, 16'd1);
    repeat (N) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_dout_vld", dout_valid, 0);
    chk("mid_rst_din_rdy", din_ready, 0);
    chk("mid_rst_tap_rdy", tap_ready, 0);
    chk("mid_rst_tap_done", tap_done, 0);
    @(negedge clk);
    release_and_count("rerun");
    load_taps(16'd1, 16'd2, 16'd3, 16'd4);
    // ch0 held stale 0x7FFF samples before reset; a clean impulse proves the clear.
    for (int i = 0; i < 4; i++)
      run($sformatf("post_rst%0d", i), 1'b0, (i == 0) ? 16'd1 : 16'd0, imp_exp[i]);

    // Reload with reversed taps
    pulse_reload();
    load_taps(16'd4, 16'd3, 16'd2, 16'd1);
    for (int i = 0; i < 4; i++)
      run($sformatf("rev%0d", i), 1'b0, (i == 0) ? 16'd1 : 16'd0, 16'(4 - i));

    // Enable drop with output pending: output discarded, head unchanged.
    dout_ready = 1'b0;
    send(1'b0, 16'd1);
    wait_valid(lat);
    chk("en_lat", lat, N + 2);
    chk("en_dout", dout, 16'd4);
    enable = 1'b0;
    @(negedge clk);
    chk("en_vld_drop", dout_valid, 0);
    enable = 1'b1;
    dout_ready = 1'b1;
    // Same head slot is overwritten with 0, so the result is 0; an advanced
    // head would leave the earlier 1 one tap back and give 3.
    run("en_head", 1'b0, 16'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
